m_ctrl_fsm: RTL and testbench
=============================

# m_ctrl_fsm

Multicycle control unit for the `M_datapath` MIPS core. It is a Moore FSM, with fetch gated by `MIO_ready`, that decodes the instruction register and drives every datapath control input each cycle. It sits beside `M_datapath` and sequences fetch, decode, execute, memory and write-back for a fixed MIPS subset. It also handshakes with the memory/IO bus through `MIO_ready`.

## Interface
- Parameters: none (opcode/funct encodings are fixed MIPS values listed under Operation)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; state <= IF on the next edge
- MIO_ready  in  1  memory/IO transfer completes this cycle
- OP  in  6  Inst[31:26] from IR
- Func  in  6  Inst[5:0] from IR
- zero  in  1  ALU zero flag (informational; branch gating is done in datapath)
- MemRead, MemWrite  out  1 each  bus request strobes
- IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  out  1 each  datapath controls
- RegDst, MemtoReg, ALUSrcB, PCSource  out  2 each  datapath mux selects
- ALU_operation  out  4  ALU op code
- state  out  4  current state encoding (debug)
- illegal  out  1  high while in ERR

## Operation
- ALU codes: and 0000, or 0001, add 0010, xor 0011, nor 0100, srl 0101, sub 0110, slt 0111, sll 1000.
- Mux encodings:
  - RegDst: 00 rt, 01 rd, 10 r31.
  - MemtoReg: 00 ALUout, 01 MDR, 10 lui, 11 PC.
  - ALUSrcA: 0 PC, 1 rs.
  - ALUSrcB: 00 rt, 01 4, 10 imm, 11 imm<<2.
  - PCSource: 00 ALU res, 01 ALUout, 10 jump target.
- Default for all 1-bit outputs is 0. Default for multi-bit outputs is 00/0000, except where a state specifies otherwise.
- States (encoding: name, asserted outputs -> next state):
  - 0 IF: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSource=00, PCWrite, IRWrite=MIO_ready -> ID if MIO_ready, else IF.
  - 1 ID: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUout) -> dispatch on OP/Func.
  - 2 MADR: ALUSrcA=1, ALUSrcB=10, add -> MRD (lw) or MWR (sw).
  - 3 MRD: MemRead, IorD=1, same ALU setup as MADR so that ALUout holds the address -> LWB if MIO_ready, else MRD.
  - 4 LWB: RegDst=00, MemtoReg=01, RegWrite -> IF.
  - 5 MWR: MemWrite, IorD=1, same ALU setup as MADR -> IF if MIO_ready, else MWR.
  - 6 REX: ALUSrcA=1, ALUSrcB=00, op from Func -> RWB.
  - 7 RWB: RegDst=01, MemtoReg=00, RegWrite -> IF.
  - 8 IEX: ALUSrcA=1, ALUSrcB=10, op from OP -> IWB.
  - 9 IWB: RegDst=00, MemtoReg=00, RegWrite -> IF.
  - 10 BEQ: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01, PCWriteCond, Branch -> IF.
  - 11 J: PCSource=10, PCWrite -> IF.
  - 12 JAL: PCSource=10, PCWrite, RegDst=10, MemtoReg=11, RegWrite -> IF. The write data is the pre-update PC, which already equals PC+4.
  - 13 JR: ALUSrcA=1, ALUSrcB=00, add, PCSource=00, PCWrite -> IF.
  - 14 LUI: RegDst=00, MemtoReg=10, RegWrite -> IF.
  - 15 ERR: illegal=1, all enables 0 -> ERR until reset.
- Dispatch from ID:
  - OP 000000 with Func in {100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl, 000000 sll} -> REX.
  - OP 000000 with Func 001000 -> JR.
  - 100011 -> MADR(lw); 101011 -> MADR(sw).
  - 000100 -> BEQ; 000010 -> J; 000011 -> JAL.
  - 001000 addi (add), 001010 slti (slt), 001100 andi (and), 001101 ori (or), 001110 xori (xor) -> IEX.
  - 001111 -> LUI.
  - Anything else -> ERR.
- REX and IEX select the ALU op combinationally from Func and OP, respectively.

## Timing
- All outputs are combinational from the state register (plus OP/Func in REX/IEX). IRWrite in IF additionally depends on MIO_ready.
- While reset=1, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond and RegWrite are forced to 0. After reset, state=0, illegal=0.
- Reset asserted in any state, including a wait in MRD/MWR or ERR, returns state to IF on the next edge. An in-flight bus request is dropped.
- Latency in cycles, assuming MIO_ready=1:
  - 3 cycles: beq, j, jal, jr, lui.
  - 4 cycles: R-type, I-type, sw.
  - 5 cycles: lw.
  - Each cycle MIO_ready=0 in IF/MRD/MWR adds one cycle.
- ALUout and MDR load every cycle. The FSM therefore must hold the ALU inputs constant across MRD/MWR waits, and LWB must immediately follow the MRD cycle in which MIO_ready=1.
- IR is stable from ID until the next IF completes, so OP/Func are valid in every post-IF state.

## Test plan
- Reset held for 2 cycles then released with MIO_ready=1: state=0, MemRead=1, PCWrite=1, IRWrite=1, RegWrite=0. State goes to 1 on the next edge.
- IR=0x8C220004 (lw), MIO_ready=1: states 0,1,2,3,4,0. LWB drives RegDst=00, MemtoReg=01, RegWrite=1. MRD drives IorD=1, ALU_operation=0010.
- Same lw with MIO_ready=0 for 3 cycles in MRD: FSM stays in 3 for 4 cycles with ALUSrcA=1, ALUSrcB=10 held, then moves to 4.
- IR=0x00851020 (add) then 0x10850003 (beq):
  - add passes states 0,1,6(ALU=0010),7(RegDst=01),0.
  - beq passes states 0,1,10 with ALU=0110, PCSource=01, PCWriteCond=Branch=1.
- IR=0x0C000010 (jal): state 12 drives PCSource=10, PCWrite=1, RegDst=10, MemtoReg=11, RegWrite=1. IR=0x03E00008 (jr) reaches state 13 with PCWrite=1, PCSource=00.
- IR=0xFC000000: reaches 15 and illegal=1, holds there for 10 cycles. Reset then returns the FSM to 0 with illegal=0.

Source files
------------

// File: rtl/m_ctrl_fsm.sv
// m_ctrl_fsm -- multicycle Moore control unit for the M_datapath MIPS core.
//
// Sequences fetch / decode / execute / memory / write-back for a fixed MIPS
// subset and drives every datapath control each cycle. Fetch, load and store
// wait on MIO_ready from the memory/IO bus.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   MIO_ready         bus transfer completes this cycle
//   OP, Func          IR[31:26], IR[5:0]
//   zero              ALU zero flag (branch gating lives in the datapath)
//   MemRead/MemWrite  bus request strobes
//   IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch
//                     1-bit datapath controls
//   RegDst, MemtoReg, ALUSrcB, PCSource
//                     2-bit datapath mux selects
//   ALU_operation     4-bit ALU op code
//   state             current state (debug)
//   illegal           high while in ERR
module m_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       MIO_ready,
    input  logic [5:0] OP,
    input  logic [5:0] Func,
    input  logic       zero,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       Branch,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALU_operation,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,  S_ID  = 4'd1,  S_MADR = 4'd2,  S_MRD = 4'd3,
        S_LWB  = 4'd4,  S_MWR = 4'd5,  S_REX  = 4'd6,  S_RWB = 4'd7,
        S_IEX  = 4'd8,  S_IWB = 4'd9,  S_BEQ  = 4'd10, S_J   = 4'd11,
        S_JAL  = 4'd12, S_JR  = 4'd13, S_LUI  = 4'd14, S_ERR = 4'd15
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001,
                           ALU_ADD = 4'b0010, ALU_XOR = 4'b0011,
                           ALU_NOR = 4'b0100, ALU_SRL = 4'b0101,
                           ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
                           ALU_SLL = 4'b1000;

    state_t cur, nxt;

    // zero is informational only; the datapath does the branch gating.
    logic unused_zero;
    assign unused_zero = zero;

    // R-type function decode: valid flag plus ALU op.
    logic       r_ok;
    logic [3:0] r_alu;
    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (Func)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            6'b000010: r_alu = ALU_SRL;
            6'b000000: r_alu = ALU_SLL;
            default:   r_ok  = 1'b0;
        endcase
    end

    // I-type ALU opcode decode.
    logic       i_ok;
    logic [3:0] i_alu;
    always_comb begin
        i_ok  = 1'b1;
        i_alu = ALU_ADD;
        case (OP)
            6'b001000: i_alu = ALU_ADD;
            6'b001010: i_alu = ALU_SLT;
            6'b001100: i_alu = ALU_AND;
            6'b001101: i_alu = ALU_OR;
            6'b001110: i_alu = ALU_XOR;
            default:   i_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) cur <= S_IF;
        else       cur <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        case (cur)
            S_IF:   nxt = MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (OP)
                    6'b000000: begin
                        if (Func == 6'b001000) nxt = S_JR;
                        else if (r_ok)         nxt = S_REX;
                        else                   nxt = S_ERR;
                    end
                    6'b100011, 6'b101011: nxt = S_MADR;
                    6'b000100:            nxt = S_BEQ;
                    6'b000010:            nxt = S_J;
                    6'b000011:            nxt = S_JAL;
                    6'b001111:            nxt = S_LUI;
                    default:              nxt = i_ok ? S_IEX : S_ERR;
                endcase
            end
            S_MADR: nxt = (OP == 6'b101011) ? S_MWR : S_MRD;
            S_MRD:  nxt = MIO_ready ? S_LWB : S_MRD;
            S_MWR:  nxt = MIO_ready ? S_IF  : S_MWR;
            S_REX:  nxt = S_RWB;
            S_IEX:  nxt = S_IWB;
            S_ERR:  nxt = S_ERR;
            default: nxt = S_IF;  // LWB, RWB, IWB, BEQ, J, JAL, JR, LUI
        endcase
    end

    // Output logic
    always_comb begin
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = ALU_AND;
        illegal       = 1'b0;
        case (cur)
            S_IF: begin
                MemRead       = 1'b1;
                ALUSrcB       = 2'b01;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
                IRWrite       = MIO_ready;
            end
            S_ID: begin
                ALUSrcB       = 2'b11;
                ALU_operation = ALU_ADD;
            end
            // MRD/MWR keep the MADR ALU setup so ALUout (reloaded every
            // cycle) still holds the address across bus waits.
            S_MADR, S_MRD, S_MWR: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = ALU_ADD;
                MemRead       = (cur == S_MRD);
                MemWrite      = (cur == S_MWR);
                IorD          = (cur != S_MADR);
            end
            S_LWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_REX: begin
                ALUSrcA       = 1'b1;
                ALU_operation = r_alu;
            end
            S_RWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_IEX: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = i_alu;
            end
            S_IWB:  RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                PCSource      = 2'b01;
                PCWriteCond   = 1'b1;
                Branch        = 1'b1;
            end
            S_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            // PC was already advanced in IF, so writing PC gives the link.
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
                RegWrite = 1'b1;
            end
            S_JR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
            end
            S_LUI: begin
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_ERR:  illegal = 1'b1;
            default: ;
        endcase
        // Drop any state-changing strobe while reset is held.
        if (reset) begin
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// Directed self-checking bench for m_ctrl_fsm.
module tb_m_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset, MIO_ready, zero;
    logic [31:0] ir;
    logic       MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA;
    logic       PCWrite, PCWriteCond, Branch, illegal;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [3:0] ALU_operation, state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_ctrl_fsm dut (
        .clk(clk), .reset(reset), .MIO_ready(MIO_ready),
        .OP(ir[31:26]), .Func(ir[5:0]), .zero(zero),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALU_operation(ALU_operation),
        .state(state), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch + decode of one instruction; leaves the FSM in the state after ID.
    task automatic fetch(input logic [31:0] w);
        ir = w;
        MIO_ready = 1'b1;
        #1;
        chk("if_state", state, 0);
        chk("if_irwrite", IRWrite, 1);
        tick();
        chk("id_state", state, 1);
        chk("id_alusrcb", ALUSrcB, 2'b11);
        tick();
    endtask

    typedef struct {
        logic [31:0] w;
        logic [3:0]  ex;
        logic [3:0]  alu;
        logic [3:0]  wb;
        logic [1:0]  dst;
    } alu_vec_t;

    alu_vec_t vecs[7] = '{
        '{32'h00851020, 4'd6, 4'b0010, 4'd7, 2'b01},  // add
        '{32'h00851022, 4'd6, 4'b0110, 4'd7, 2'b01},  // sub
        '{32'h00041080, 4'd6, 4'b1000, 4'd7, 2'b01},  // sll
        '{32'h00041082, 4'd6, 4'b0101, 4'd7, 2'b01},  // srl
        '{32'h00851027, 4'd6, 4'b0100, 4'd7, 2'b01},  // nor
        '{32'h34A50001, 4'd8, 4'b0001, 4'd9, 2'b00},  // ori
        '{32'h28A50001, 4'd8, 4'b0111, 4'd9, 2'b00}   // slti
    };

    initial begin
        reset = 1'b1; MIO_ready = 1'b1; zero = 1'b0; ir = 32'h0;
        tick();
        tick();
        chk("rst_memread", MemRead, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_irwrite", IRWrite, 0);
        reset = 1'b0;
        #1;
        chk("por_state", state, 0);
        chk("por_memread", MemRead, 1);
        chk("por_pcwrite", PCWrite, 1);
        chk("por_irwrite", IRWrite, 1);
        chk("por_regwrite", RegWrite, 0);
        chk("por_illegal", illegal, 0);

        // IF stall
        MIO_ready = 1'b0;
        #1;
        chk("ifw_irwrite", IRWrite, 0);
        tick();
        chk("ifw_state", state, 0);

        // lw, no waits
        fetch(32'h8C220004);
        chk("lw_madr", state, 2);
        chk("lw_madr_srca", ALUSrcA, 1);
        chk("lw_madr_srcb", ALUSrcB, 2'b10);
        tick();
        chk("lw_mrd", state, 3);
        chk("lw_mrd_iord", IorD, 1);
        chk("lw_mrd_memread", MemRead, 1);
        chk("lw_mrd_alu", ALU_operation, 4'b0010);
        tick();
        chk("lw_lwb", state, 4);
        chk("lw_lwb_dst", RegDst, 2'b00);
        chk("lw_lwb_m2r", MemtoReg, 2'b01);
        chk("lw_lwb_rw", RegWrite, 1);
        tick();
        chk("lw_done", state, 0);

        // lw with 3 wait cycles in MRD
        fetch(32'h8C220004);
        tick();
        MIO_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lww_state", state, 3);
            chk("lww_srca", ALUSrcA, 1);
            chk("lww_srcb", ALUSrcB, 2'b10);
            tick();
        end
        MIO_ready = 1'b1;
        #1;
        chk("lww_last", state, 3);
        tick();
        chk("lww_lwb", state, 4);
        tick();

        // sw with one wait in MWR
        fetch(32'hAC220004);
        tick();
        MIO_ready = 1'b0;
        #1;
        chk("sw_mwr", state, 5);
        chk("sw_memwrite", MemWrite, 1);
        chk("sw_iord", IorD, 1);
        chk("sw_memread", MemRead, 0);
        tick();
        chk("sw_hold", state, 5);
        MIO_ready = 1'b1;
        tick();
        chk("sw_done", state, 0);

        // R-type / I-type ALU table
        for (int i = 0; i < 7; i++) begin
            fetch(vecs[i].w);
            chk("alu_ex", state, vecs[i].ex);
            chk("alu_op", ALU_operation, vecs[i].alu);
            tick();
            chk("alu_wb", state, vecs[i].wb);
            chk("alu_dst", RegDst, vecs[i].dst);
            chk("alu_rw", RegWrite, 1);
            tick();
            chk("alu_done", state, 0);
        end

        // beq
        fetch(32'h10850003);
        chk("beq_state", state, 10);
        chk("beq_alu", ALU_operation, 4'b0110);
        chk("beq_pcsrc", PCSource, 2'b01);
        chk("beq_cond", PCWriteCond, 1);
        chk("beq_branch", Branch, 1);
        tick();
        chk("beq_done", state, 0);

        // j
        fetch(32'h08000010);
        chk("j_state", state, 11);
        chk("j_pcsrc", PCSource, 2'b10);
        chk("j_pcwrite", PCWrite, 1);
        tick();

        // jal
        fetch(32'h0C000010);
        chk("jal_state", state, 12);
        chk("jal_pcsrc", PCSource, 2'b10);
        chk("jal_pcwrite", PCWrite, 1);
        chk("jal_dst", RegDst, 2'b10);
        chk("jal_m2r", MemtoReg, 2'b11);
        chk("jal_rw", RegWrite, 1);
        tick();

        // jr
        fetch(32'h03E00008);
        chk("jr_state", state, 13);
        chk("jr_pcwrite", PCWrite, 1);
        chk("jr_pcsrc", PCSource, 2'b00);
        chk("jr_alu", ALU_operation, 4'b0010);
        tick();

        // lui
        fetch(32'h3C011234);
        chk("lui_state", state, 14);
        chk("lui_m2r", MemtoReg, 2'b10);
        chk("lui_rw", RegWrite, 1);
        tick();
        chk("lui_done", state, 0);

        // illegal opcode, sticky until reset
        fetch(32'hFC000000);
        for (int i = 0; i < 10; i++) begin
            chk("err_state", state, 15);
            chk("err_illegal", illegal, 1);
            chk("err_pcwrite", PCWrite, 0);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("err_rst_state", state, 0);
        chk("err_rst_illegal", illegal, 0);
        chk("err_rst_memread", MemRead, 0);
        reset = 1'b0;
        #1;
        chk("err_rel_memread", MemRead, 1);

        // reset during an MRD wait drops the bus request
        fetch(32'h8C220004);
        tick();
        MIO_ready = 1'b0;
        tick();
        chk("mrdr_state", state, 3);
        reset = 1'b1;
        #1;
        chk("mrdr_memread", MemRead, 0);
        tick();
        chk("mrdr_rst", state, 0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
